// File: rtl/ftdi_model_pkg.sv
// ftdi_model_pkg
//   Shared helpers for the FTDI synchronous 245-FIFO chip model:
//   bus width helpers derived from CHIP_EW, byte-enable popcount and
//   contiguity check, and the LFSR seed/tap constants used by the
//   optional pseudo-random flow control.
package ftdi_model_pkg;

   // Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Data bus width in bits: 8, 16 or 32
   function automatic int data_w(input int chip_ew);
      return 8 << chip_ew;
   endfunction

   // Number of byte enables: 1, 2 or 4
   function automatic int be_w(input int chip_ew);
      return 1 << chip_ew;
   endfunction

   // Number of set byte enables (narrower buses are zero-extended)
   function automatic logic [2:0] popcount(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   // Legal BE: non-zero and a solid run of ones starting at bit 0
   function automatic logic be_contig(input logic [3:0] v);
      logic [3:0] v_inc;
      v_inc = v + 4'd1;
      return (v != 4'd0) && ((v & v_inc) == 4'd0);
   endfunction

endpackage

// File: rtl/ftdi_chip_fifo_model_if.sv
// ftdi_chip_fifo_model_if
//   FIFO handshake strobes between the FPGA controller (master) and the
//   FTDI chip model (slave).
//   ftdi_rxf_n : chip -> FPGA, low = RX data available
//   ftdi_txe_n : chip -> FPGA, low = TX space available
//   ftdi_oe_n  : FPGA -> chip, low = chip drives the data bus
//   ftdi_rd_n  : FPGA -> chip, low = pop one RX word
//   ftdi_wr_n  : FPGA -> chip, low = push one TX word
interface ftdi_chip_fifo_model_if;
   logic ftdi_rxf_n;
   logic ftdi_txe_n;
   logic ftdi_oe_n;
   logic ftdi_rd_n;
   logic ftdi_wr_n;

   modport master (output ftdi_oe_n, ftdi_rd_n, ftdi_wr_n,
                   input  ftdi_rxf_n, ftdi_txe_n);
   modport slave  (input  ftdi_oe_n, ftdi_rd_n, ftdi_wr_n,
                   output ftdi_rxf_n, ftdi_txe_n);
endinterface

// File: rtl/ftdi_model_fifo.sv
// ftdi_model_fifo
//   Synchronous first-word-fall-through FIFO; head always shows the
//   oldest entry. Pushes while full and pops while empty are dropped.
//   clk, rst   : clock, asynchronous active-high reset
//   push/push_data, pop : write and read strobes
//   head       : oldest entry, count : occupancy, full/empty flags
module ftdi_model_fifo
   import ftdi_model_pkg::*;
#(
   parameter int DATA_W     = 36,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_W-1:0]     push_data,
   input  logic                  pop,
   output logic [DATA_W-1:0]     head,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic                  do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ftdi_chip_fifo_model.sv
// ftdi_chip_fifo_model
//   Bus-functional model of an FT232H/FT600/FT601 in synchronous
//   245-FIFO mode with real host-side RX and TX buffers.
//   ftdi_clk, rst          : chip clock, asynchronous active-high reset
//   bus (slave modport)    : rxf_n/txe_n out, oe_n/rd_n/wr_n in
//   ftdi_data, ftdi_be     : bidirectional data bus and byte enables
//   host_rx_en, host_tx_en : enable host packet producer / TX drain
//   rx_byte_cnt            : bytes accepted by FPGA reads
//   tx_byte_cnt            : valid bytes received from FPGA writes
//   err_cnt                : saturating protocol/data error count
//   Optional macro FTDI_MODEL_LFSR_STALL_EN: LFSR-driven producer and
//   drain stalls for reproducible pseudo-random flow control.
module ftdi_chip_fifo_model
   import ftdi_model_pkg::*;
#(
   parameter int CHIP_EW       = 0,
   parameter int RX_DEPTH_LOG2 = 9,
   parameter int TX_DEPTH_LOG2 = 9,
   parameter int RX_PKT_BYTES  = 1023,
   parameter int TX_DRAIN_DIV  = 1
) (
   input  logic                         ftdi_clk,
   input  logic                         rst,
   ftdi_chip_fifo_model_if.slave        bus,
   inout  wire  [data_w(CHIP_EW)-1:0]   ftdi_data,
   inout  wire  [be_w(CHIP_EW)-1:0]     ftdi_be,
   input  logic                         host_rx_en,
   input  logic                         host_tx_en,
   output logic [31:0]                  rx_byte_cnt,
   output logic [31:0]                  tx_byte_cnt,
   output logic [15:0]                  err_cnt
);
   localparam int W   = data_w(CHIP_EW);
   localparam int B   = be_w(CHIP_EW);
   localparam int RXC = RX_DEPTH_LOG2 + 1;
   localparam int TXC = TX_DEPTH_LOG2 + 1;
   localparam logic [TXC-1:0] TX_FULL  = TXC'(1 << TX_DEPTH_LOG2);
   localparam logic [7:0]     DIV_LAST = 8'(TX_DRAIN_DIV - 1);

   logic [7:0]     rx_pat, tx_byte, div_cnt;
   logic [15:0]    rx_pkt_cnt;
   logic [16:0]    rx_rem, err_sum;
   logic           rx_last, rx_push, rx_pop, rd_err, tx_push, tx_pop;
   logic           rx_full, rx_empty, tx_full, tx_empty, stall_rx, stall_tx;
   logic [W-1:0]   rx_data_new, rx_head_data;
   logic [B-1:0]   rx_be_new, rx_head_be;
   logic [W+B-1:0] rx_head, tx_head_unused;
   logic [RXC-1:0] rx_count, rx_cnt_nxt;
   logic [TXC-1:0] tx_count, tx_cnt_nxt;
   logic [2:0]     tx_err_add, tx_pc;

`ifdef FTDI_MODEL_LFSR_STALL_EN
   logic [15:0] lfsr;
   always_ff @(posedge ftdi_clk or posedge rst) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
   end
   assign stall_rx = lfsr[0];
   assign stall_tx = lfsr[1];
`else
   assign stall_rx = 1'b0;
   assign stall_tx = 1'b0;
`endif

   // Producer word: every lane carries the running pattern, even padding
   // lanes of a packet's last word; only BE marks them invalid.
   assign rx_rem  = 17'(RX_PKT_BYTES) - {1'b0, rx_pkt_cnt};
   assign rx_last = (rx_rem <= 17'(B));

   always_comb begin
      rx_data_new = '0;
      rx_be_new   = '0;
      for (int i = 0; i < B; i++) begin
         rx_data_new[8*i +: 8] = rx_pat + 8'(i);
         rx_be_new[i]          = !rx_last || (17'(i) < rx_rem);
      end
   end

   assign rx_push = host_rx_en & ~rx_full & ~stall_rx;
   assign rx_pop  = ~bus.ftdi_rd_n & ~bus.ftdi_rxf_n & ~bus.ftdi_oe_n & ~rx_empty;
   assign rd_err  = ~bus.ftdi_rd_n & ~bus.ftdi_rxf_n &  bus.ftdi_oe_n;
   assign tx_push = ~bus.ftdi_wr_n & ~bus.ftdi_txe_n & ~tx_full;
   assign tx_pop  = host_tx_en & ~tx_empty & (div_cnt == '0) & ~stall_tx;

   assign {rx_head_be, rx_head_data} = rx_head;
   assign ftdi_data = bus.ftdi_oe_n ? 'z : rx_head_data;
   assign ftdi_be   = bus.ftdi_oe_n ? 'z : rx_head_be;

   // Flags are registered from the post-edge occupancy so they track the
   // buffer count without a cycle of lag.
   assign rx_cnt_nxt = rx_count + RXC'(rx_push) - RXC'(rx_pop);
   assign tx_cnt_nxt = tx_count + TXC'(tx_push) - TXC'(tx_pop);

   // TX capture check: lane i must hold txbyte + i.
   assign tx_pc = popcount(4'(ftdi_be));
   always_comb begin
      tx_err_add = '0;
      if (tx_push) begin
         if (!be_contig(4'(ftdi_be))) tx_err_add = tx_err_add + 3'd1;
         for (int i = 0; i < B; i++) begin
            if (ftdi_be[i] && (ftdi_data[8*i +: 8] != tx_byte + 8'(i)))
               tx_err_add = tx_err_add + 3'd1;
         end
      end
   end

   assign err_sum = {1'b0, err_cnt} + 17'(tx_err_add) + 17'(rd_err);

   always_ff @(posedge ftdi_clk or posedge rst) begin
      if (rst) begin
         bus.ftdi_rxf_n <= 1'b1;
         bus.ftdi_txe_n <= 1'b1;
         rx_pat         <= '0;
         rx_pkt_cnt     <= '0;
         tx_byte        <= '0;
         div_cnt        <= '0;
         rx_byte_cnt    <= '0;
         tx_byte_cnt    <= '0;
         err_cnt        <= '0;
      end else begin
         bus.ftdi_rxf_n <= (rx_cnt_nxt == '0);
         bus.ftdi_txe_n <= (tx_cnt_nxt == TX_FULL);
         if (rx_push) begin
            rx_pat     <= rx_pat + 8'(B);
            rx_pkt_cnt <= rx_last ? '0 : rx_pkt_cnt + 16'(B);
         end
         if (rx_pop) rx_byte_cnt <= rx_byte_cnt + 32'(popcount(4'(rx_head_be)));
         if (tx_push) begin
            tx_byte_cnt <= tx_byte_cnt + 32'(tx_pc);
            tx_byte     <= tx_byte + 8'(tx_pc);
         end
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 8'd1;
         err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

   ftdi_model_fifo #(.DATA_W(W + B), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
      .clk(ftdi_clk), .rst(rst), .push(rx_push), .push_data({rx_be_new, rx_data_new}),
      .pop(rx_pop), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty));

   ftdi_model_fifo #(.DATA_W(W + B), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
      .clk(ftdi_clk), .rst(rst), .push(tx_push), .push_data({ftdi_be, ftdi_data}),
      .pop(tx_pop), .head(tx_head_unused), .count(tx_count), .full(tx_full), .empty(tx_empty));
endmodule
